// File: rtl/column_alu_pkg.sv
// Shared constants, opcode encoding and decode helpers for the column ALU.
package column_alu_pkg;

   localparam int DEF_NUM_SIZE      = 32;
   localparam int DEF_CMD_SIZE_LOG2 = 2;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_EQ   = 4'd2,
      OP_LT   = 4'd3,
      OP_GT   = 4'd4,
      OP_MIN  = 4'd5,
      OP_MAX  = 4'd6,
      OP_SUM  = 4'd8,
      OP_CNT  = 4'd9,
      OP_AMIN = 4'd10,
      OP_AMAX = 4'd11
   } alu_cmd_t;

   typedef enum logic {
      ST_IDLE,
      ST_ACCUM
   } agg_state_t;

   function automatic logic is_elem_op(input logic [3:0] c);
      return c <= 4'd6;
   endfunction

   function automatic logic is_agg_op(input logic [3:0] c);
      return (c >= 4'd8) && (c <= 4'd11);
   endfunction

endpackage

// File: rtl/column_alu_agg.sv
// Group aggregator: IDLE/ACCUM FSM, latched group opcode, accumulator,
// sticky group overflow / count saturation. Produces the group value
// combinationally for the current beat so the top can register it on the
// last beat without an extra cycle.
module column_alu_agg
   import column_alu_pkg::*;
#(
   parameter int NUM_SIZE = DEF_NUM_SIZE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                beat_en,
   input  logic [NUM_SIZE-1:0] in1,
   input  logic                in_last,
   input  logic [3:0]          cmd,
   output logic                busy,
   output logic [NUM_SIZE-1:0] res_data,
   output logic                res_flag
);

   localparam logic [NUM_SIZE-1:0] ONE     = NUM_SIZE'(1);
   localparam logic [NUM_SIZE-1:0] CNT_MAX = {1'b0, {(NUM_SIZE-1){1'b1}}};
   localparam int                  M       = NUM_SIZE - 1;

   agg_state_t          state_q, state_d;
   logic [3:0]          grp_cmd_q, grp_cmd_d;
   logic [NUM_SIZE-1:0] acc_q, acc_d;
   logic                ovf_q, ovf_d;

   logic [3:0]          eff_cmd;
   logic [NUM_SIZE-1:0] sum, acc_new;
   logic                ovf_new;

   assign busy = (state_q == ST_ACCUM);

   // Group update for the current beat plus next-state selection.
   always_comb begin
      state_d   = state_q;
      grp_cmd_d = grp_cmd_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      // Inside a group the opcode on the bus is ignored.
      eff_cmd   = (state_q == ST_ACCUM) ? grp_cmd_q : cmd;
      sum       = acc_q + in1;
      acc_new   = acc_q;
      ovf_new   = ovf_q;
      if (state_q == ST_IDLE) begin
         acc_new = (eff_cmd == OP_CNT) ? ONE : in1;
         ovf_new = 1'b0;
      end else begin
         case (eff_cmd)
            OP_SUM: begin
               acc_new = sum;
               ovf_new = ovf_q | ((acc_q[M] == in1[M]) && (sum[M] != acc_q[M]));
            end
            OP_CNT: begin
               if (acc_q == CNT_MAX) ovf_new = 1'b1;
               else                  acc_new = acc_q + ONE;
            end
            OP_AMIN: if ($signed(in1) < $signed(acc_q)) acc_new = in1;
            OP_AMAX: if ($signed(in1) > $signed(acc_q)) acc_new = in1;
            default: ;
         endcase
      end
      res_data = acc_new;
      res_flag = ((eff_cmd == OP_SUM) || (eff_cmd == OP_CNT)) ? ovf_new : 1'b0;
      if (beat_en) begin
         if (in_last) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
         end else begin
            state_d = ST_ACCUM;
            acc_d   = acc_new;
            ovf_d   = ovf_new;
            if (state_q == ST_IDLE) grp_cmd_d = cmd;
         end
      end
   end

   // Group state registers; reset drops any open group.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         grp_cmd_q <= OP_SUM;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         grp_cmd_q <= grp_cmd_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
      end
   end

endmodule

// File: rtl/column_alu.sv
// Streaming column ALU: element-wise arithmetic/compare, group aggregates,
// single output register with valid/ready handshake, sticky illegal-op flag.
module column_alu
   import column_alu_pkg::*;
#(
   parameter int NUM_SIZE      = DEF_NUM_SIZE,
   parameter int CMD_SIZE_LOG2 = DEF_CMD_SIZE_LOG2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NUM_SIZE-1:0]         in1,
   input  logic [NUM_SIZE-1:0]         in2,
   input  logic                        in_last,
   input  logic [2**CMD_SIZE_LOG2-1:0] cmd,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NUM_SIZE-1:0]         out_data,
   output logic                        out_flag,
   output logic                        out_last,
   output logic                        err_opcode
);

   localparam int M = NUM_SIZE - 1;

   logic [3:0]          op;
   logic                hi_zero, op_elem, op_agg;
   logic                fire, agg_busy, agg_beat, elem_beat, bad_beat, produce;
   logic [NUM_SIZE-1:0] agg_data, elem_data, sum, diff;
   logic                agg_flag, elem_flag, a_lt_b, a_eq_b;

   logic                out_valid_q, out_valid_d;
   logic [NUM_SIZE-1:0] out_data_q, out_data_d;
   logic                out_flag_q, out_flag_d;
   logic                out_last_q, out_last_d;
   logic                err_q, err_d;

   // Any set bit above the 4-bit opcode space makes the code illegal.
   assign op        = cmd[3:0];
   assign hi_zero   = (cmd >> 4) == '0;
   assign op_elem   = hi_zero && is_elem_op(op);
   assign op_agg    = hi_zero && is_agg_op(op);

   assign in_ready  = !reset && (!out_valid_q || out_ready);
   assign fire      = in_valid && in_ready;
   assign agg_beat  = fire && (agg_busy || op_agg);
   assign elem_beat = fire && !agg_busy && op_elem;
   assign bad_beat  = fire && !agg_busy && !op_elem && !op_agg;
   assign produce   = elem_beat || (agg_beat && in_last);

   column_alu_agg #(.NUM_SIZE(NUM_SIZE)) u_agg (
      .clk      (clk),
      .reset    (reset),
      .beat_en  (agg_beat),
      .in1      (in1),
      .in_last  (in_last),
      .cmd      (op),
      .busy     (agg_busy),
      .res_data (agg_data),
      .res_flag (agg_flag)
   );

   // Element-wise datapath for the opcode on the bus.
   always_comb begin
      sum       = in1 + in2;
      diff      = in1 - in2;
      a_lt_b    = $signed(in1) < $signed(in2);
      a_eq_b    = (in1 == in2);
      elem_data = '0;
      elem_flag = 1'b0;
      case (op)
         OP_ADD: begin
            elem_data = sum;
            elem_flag = (in1[M] == in2[M]) && (sum[M] != in1[M]);
         end
         OP_SUB: begin
            elem_data = diff;
            elem_flag = (in1[M] != in2[M]) && (diff[M] != in1[M]);
         end
         OP_EQ:  elem_flag = a_eq_b;
         OP_LT:  elem_flag = a_lt_b;
         OP_GT:  elem_flag = !a_lt_b && !a_eq_b;
         // flag marks in2 selected; ties keep in1
         OP_MIN: begin
            elem_flag = !a_lt_b && !a_eq_b;
            elem_data = elem_flag ? in2 : in1;
         end
         OP_MAX: begin
            elem_flag = a_lt_b;
            elem_data = elem_flag ? in2 : in1;
         end
         default: ;
      endcase
      if ((op == OP_EQ) || (op == OP_LT) || (op == OP_GT))
         elem_data = {{(NUM_SIZE-1){1'b0}}, elem_flag};
   end

   // Output register: drop on accept, reload when a beat produces a result.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_flag_d  = out_flag_q;
      out_last_d  = out_last_q;
      err_d       = err_q | bad_beat;
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_flag_d  = 1'b0;
         out_last_d  = 1'b0;
      end
      if (produce) begin
         out_valid_d = 1'b1;
         out_data_d  = agg_beat ? agg_data : elem_data;
         out_flag_d  = agg_beat ? agg_flag : elem_flag;
         out_last_d  = agg_beat ? 1'b1 : in_last;
      end
   end

   // Output and error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_flag_q  <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_flag_q  <= out_flag_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_flag   = out_flag_q;
   assign out_last   = out_last_q;
   assign err_opcode = err_q;

endmodule

// File: tb/tb_column_alu.sv
// Bench for column_alu: element-wise vector table, hand-written multi-cycle
// sequences, and a randomized stream against a list-based reference model.
module tb_column_alu;

   localparam int N = 32;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, in_last;
   logic         out_valid, out_ready, out_flag, out_last, err_opcode;
   logic [N-1:0] in1, in2, out_data;
   logic [3:0]   cmd;

   always #5 clk = ~clk;

   column_alu #(.NUM_SIZE(N), .CMD_SIZE_LOG2(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in1        (in1),
      .in2        (in2),
      .in_last    (in_last),
      .cmd        (cmd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_flag   (out_flag),
      .out_last   (out_last),
      .err_opcode (err_opcode)
   );

   typedef struct { logic [3:0] cmd; logic [N-1:0] a; logic [N-1:0] b; logic last; } beat_t;
   typedef struct { logic [N-1:0] data; logic flag; logic last; } res_t;
   typedef struct {
      logic [3:0] cmd; logic [N-1:0] a; logic [N-1:0] b; logic last;
      logic [N-1:0] exp_data; logic exp_flag;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   beat_t        stim_q[$];
   res_t         exp_q[$];
   bit           m_in_grp;
   logic [3:0]   m_grp_cmd;
   logic [N-1:0] m_vals[$];
   bit           m_err;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input beat_t b);
      cmd = b.cmd; in1 = b.a; in2 = b.b; in_last = b.last;
   endtask

   function automatic beat_t mk(input logic [3:0] c, input logic [N-1:0] a,
                                input logic [N-1:0] b, input logic l);
      beat_t r;
      r.cmd = c; r.a = a; r.b = b; r.last = l;
      return r;
   endfunction

   // ---------------- reference model (plain integer arithmetic) ----------
   function automatic longint sx(input logic [N-1:0] v);
      return longint'($signed(v));
   endfunction

   function automatic res_t elem_ref(input beat_t b);
      res_t   r;
      longint x, y, t;
      bit     c;
      x = sx(b.a); y = sx(b.b);
      r.last = b.last; r.flag = 1'b0; r.data = b.a;
      case (b.cmd)
         4'd0, 4'd1: begin
            t = (b.cmd == 4'd0) ? x + y : x - y;
            r.data = t[N-1:0];
            r.flag = (t > MAXV) || (t < MINV);
         end
         4'd2, 4'd3, 4'd4: begin
            c = (b.cmd == 4'd2) ? (x == y) : (b.cmd == 4'd3) ? (x < y) : (x > y);
            r.flag = c;
            r.data = c ? 32'd1 : 32'd0;
         end
         4'd5: begin r.flag = (y < x); r.data = r.flag ? b.b : b.a; end
         default: begin r.flag = (y > x); r.data = r.flag ? b.b : b.a; end
      endcase
      return r;
   endfunction

   function automatic res_t agg_ref(input logic [3:0] c);
      res_t   r;
      longint acc, t;
      r.last = 1'b1; r.flag = 1'b0;
      acc = sx(m_vals[0]);
      case (c)
         4'd8: begin
            for (int i = 1; i < m_vals.size(); i++) begin
               t = acc + sx(m_vals[i]);
               if ((t > MAXV) || (t < MINV)) r.flag = 1'b1;
               acc = sx(t[N-1:0]);
            end
         end
         4'd9: begin
            acc = m_vals.size();
            if (acc > MAXV) begin acc = MAXV; r.flag = 1'b1; end
         end
         4'd10: foreach (m_vals[i]) if (sx(m_vals[i]) < acc) acc = sx(m_vals[i]);
         default: foreach (m_vals[i]) if (sx(m_vals[i]) > acc) acc = sx(m_vals[i]);
      endcase
      r.data = acc[N-1:0];
      return r;
   endfunction

   task automatic model_accept(input beat_t b);
      if (m_in_grp) begin
         m_vals.push_back(b.a);
         if (b.last) begin
            exp_q.push_back(agg_ref(m_grp_cmd));
            m_in_grp = 0;
            m_vals.delete();
         end
      end else if (b.cmd <= 4'd6) begin
         exp_q.push_back(elem_ref(b));
      end else if (b.cmd >= 4'd8 && b.cmd <= 4'd11) begin
         m_vals.delete();
         m_vals.push_back(b.a);
         if (b.last) begin
            exp_q.push_back(agg_ref(b.cmd));
            m_vals.delete();
         end else begin
            m_in_grp  = 1;
            m_grp_cmd = b.cmd;
         end
      end else begin
         m_err = 1;
      end
   endtask

   // Stream stim_q through the DUT with random gaps and back-pressure.
   task automatic run(input int rdy_pct, input int budget);
      int    cyc;
      res_t  r;
      beat_t b;
      cyc = 0;
      while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
         tick();
         cyc++;
         out_ready = ($urandom_range(0, 99) < rdy_pct);
         if (stim_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            drive(stim_q[0]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_result: got %h with nothing expected", out_data);
            end else begin
               r = exp_q.pop_front();
               chk("stream_data", out_data, r.data);
               chk1("stream_flag", out_flag, r.flag);
               chk1("stream_last", out_last, r.last);
            end
         end
         if (in_valid && in_ready) begin
            b = stim_q.pop_front();
            model_accept(b);
         end
      end
      n_cmp++;
      if (cyc >= budget) begin
         n_bad++;
         $display("FAIL run_timeout: %0d beats and %0d results left", stim_q.size(), exp_q.size());
         stim_q.delete();
         exp_q.delete();
      end
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk1("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk1("rst_out_flag", out_flag, 1'b0);
      chk1("rst_out_last", out_last, 1'b0);
      chk1("rst_err", err_opcode, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b0);
      tick();
      reset = 1'b0;
      m_in_grp = 0; m_err = 0; m_vals.delete();
      stim_q.delete(); exp_q.delete();
   endtask

   function automatic logic [N-1:0] rand_val();
      case ($urandom_range(0, 3))
         0: return N'($urandom_range(0, 20)) - 32'd10;
         1: return 32'h7fffffff - N'($urandom_range(0, 3));
         2: return 32'h80000000 + N'($urandom_range(0, 3));
         default: return N'($urandom);
      endcase
   endfunction

   vec_t vt[16];

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      cmd = '0; in1 = '0; in2 = '0; in_last = 1'b0;
      m_in_grp = 0; m_err = 0; m_grp_cmd = '0;

      vt[0]  = '{4'd0, 32'h7fffffff, 32'h00000001, 1'b0, 32'h80000000, 1'b1};
      vt[1]  = '{4'd0, 32'h80000000, 32'hffffffff, 1'b1, 32'h7fffffff, 1'b1};
      vt[2]  = '{4'd0, 32'h00000005, 32'hfffffffd, 1'b0, 32'h00000002, 1'b0};
      vt[3]  = '{4'd1, 32'h80000000, 32'h00000001, 1'b1, 32'h7fffffff, 1'b1};
      vt[4]  = '{4'd1, 32'h7fffffff, 32'hffffffff, 1'b0, 32'h80000000, 1'b1};
      vt[5]  = '{4'd1, 32'h00000003, 32'h00000005, 1'b1, 32'hfffffffe, 1'b0};
      vt[6]  = '{4'd2, 32'h00000005, 32'h00000005, 1'b0, 32'h00000001, 1'b1};
      vt[7]  = '{4'd2, 32'h00000005, 32'h00000006, 1'b1, 32'h00000000, 1'b0};
      vt[8]  = '{4'd3, 32'hffffffff, 32'h00000000, 1'b0, 32'h00000001, 1'b1};
      vt[9]  = '{4'd3, 32'h00000000, 32'hffffffff, 1'b1, 32'h00000000, 1'b0};
      vt[10] = '{4'd4, 32'h80000000, 32'h7fffffff, 1'b0, 32'h00000000, 1'b0};
      vt[11] = '{4'd4, 32'h7fffffff, 32'h80000000, 1'b1, 32'h00000001, 1'b1};
      vt[12] = '{4'd5, 32'h00000003, 32'h00000003, 1'b0, 32'h00000003, 1'b0};
      vt[13] = '{4'd5, 32'h00000005, 32'hfffffffe, 1'b1, 32'hfffffffe, 1'b1};
      vt[14] = '{4'd6, 32'h00000003, 32'h00000003, 1'b0, 32'h00000003, 1'b0};
      vt[15] = '{4'd6, 32'hfffffffb, 32'h00000002, 1'b1, 32'h00000002, 1'b1};

      do_reset();

      // element-wise vector table, one beat at a time
      foreach (vt[i]) begin
         drive(mk(vt[i].cmd, vt[i].a, vt[i].b, vt[i].last));
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         chk1("vec_valid", out_valid, 1'b1);
         chk("vec_data", out_data, vt[i].exp_data);
         chk1("vec_flag", out_flag, vt[i].exp_flag);
         chk1("vec_last", out_last, vt[i].last);
         tick();
      end

      // ADD overflow: valid for exactly one cycle
      drive(mk(4'd0, 32'h7fffffff, 32'h1, 1'b0));
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk1("addovf_valid", out_valid, 1'b1);
      chk("addovf_data", out_data, 32'h80000000);
      chk1("addovf_flag", out_flag, 1'b1);
      tick();
      chk1("addovf_one_cycle", out_valid, 1'b0);

      // SUM group 5, -3, 10
      drive(mk(4'd8, 32'd5, 32'd0, 1'b0));
      in_valid = 1'b1;
      tick();
      chk1("sum_beat1_no_out", out_valid, 1'b0);
      drive(mk(4'd8, 32'hfffffffd, 32'd0, 1'b0));
      tick();
      chk1("sum_beat2_no_out", out_valid, 1'b0);
      drive(mk(4'd8, 32'd10, 32'd0, 1'b1));
      tick();
      in_valid = 1'b0;
      chk1("sum_valid", out_valid, 1'b1);
      chk("sum_data", out_data, 32'd12);
      chk1("sum_flag", out_flag, 1'b0);
      chk1("sum_last", out_last, 1'b1);
      tick();
      chk1("sum_single_result", out_valid, 1'b0);

      // back-pressure with LT beats
      drive(mk(4'd3, 32'd1, 32'd2, 1'b0));
      in_valid = 1'b1;
      tick();
      out_ready = 1'b0;
      drive(mk(4'd3, 32'd3, 32'd2, 1'b0));
      for (int k = 0; k < 3; k++) begin
         #1;
         chk1("bp_in_ready_stall", in_ready, 1'b0);
         chk1("bp_valid_stall", out_valid, 1'b1);
         chk("bp_data_stall", out_data, 32'd1);
         chk1("bp_flag_stall", out_flag, 1'b1);
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk1("bp_in_ready_release", in_ready, 1'b1);
      chk("bp_res1_data", out_data, 32'd1);
      chk1("bp_res1_flag", out_flag, 1'b1);
      tick();
      drive(mk(4'd3, 32'd2, 32'd2, 1'b0));
      #1;
      chk1("bp_res2_valid", out_valid, 1'b1);
      chk("bp_res2_data", out_data, 32'd0);
      chk1("bp_res2_flag", out_flag, 1'b0);
      tick();
      in_valid = 1'b0;
      chk1("bp_res3_valid", out_valid, 1'b1);
      chk("bp_res3_data", out_data, 32'd0);
      chk1("bp_res3_flag", out_flag, 1'b0);
      tick();
      chk1("bp_no_dup", out_valid, 1'b0);

      // CNT single-beat, then an abandoned group cut by reset
      stim_q.push_back(mk(4'd9, 32'd77, 32'd0, 1'b1));
      run(60, 200);
      for (int k = 0; k < 3; k++) stim_q.push_back(mk(4'd9, 32'd1, 32'd0, 1'b0));
      run(60, 200);
      do_reset();
      stim_q.push_back(mk(4'd9, 32'd5, 32'd0, 1'b0));
      stim_q.push_back(mk(4'd9, 32'd6, 32'd0, 1'b1));
      run(60, 200);

      // illegal opcode inside an AMAX group is ignored
      stim_q.push_back(mk(4'd11, 32'd4, 32'd0, 1'b0));
      stim_q.push_back(mk(4'd7, 32'd9, 32'd0, 1'b0));
      stim_q.push_back(mk(4'd11, 32'hffffffff, 32'd0, 1'b1));
      run(60, 200);
      chk1("err_in_group", err_opcode, 1'b0);
      stim_q.push_back(mk(4'd7, 32'd9, 32'd0, 1'b1));
      run(60, 200);
      chk1("err_idle", err_opcode, 1'b1);
      chk1("err_no_output", out_valid, 1'b0);

      // randomized stream against the model
      do_reset();
      for (int k = 0; k < 400; k++)
         stim_q.push_back(mk(4'($urandom_range(0, 15)), rand_val(), rand_val(),
                             $urandom_range(0, 2) == 0));
      run(70, 4000);
      chk1("rand_err", err_opcode, m_err);
      chk1("rand_idle", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
